pfb_reload_arbiter: RTL

- Shares the single PFB coefficient reload stream between two independent coefficient sources: port 0 (host/register path) and port 1 (preset sequencer).
- Packet-atomic round-robin arbiter. Once a source is granted, its whole coefficient set up to tlast passes through before the other source is considered.
- Sits directly upstream of the PFB memory controller's reload slave port.
- Honours that port's tready, which stays low during the controller's post-reload config sweep.

---
 rtl/pfb_reload_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pfb_reload_arbiter.sv
// pfb_reload_arbiter: packet-atomic round-robin arbiter feeding the PFB coefficient reload port
// Optional set-length policing with overlong-set drain is compiled in by PFB_RELOAD_LEN_CHECK_EN.
module pfb_reload_arbiter #(
    parameter int DATA_W     = 32,
    parameter int NUM_COEFFS = 65536,
    parameter int CNT_W      = 17
) (
    input  logic              clk,
    input  logic              sync_reset,
    input  logic              s0_axis_tvalid,
    input  logic [DATA_W-1:0] s0_axis_tdata,
    input  logic              s0_axis_tlast,
    output logic              s0_axis_tready,
    input  logic              s1_axis_tvalid,
    input  logic [DATA_W-1:0] s1_axis_tdata,
    input  logic              s1_axis_tlast,
    output logic              s1_axis_tready,
    output logic              m_axis_reload_tvalid,
    output logic [DATA_W-1:0] m_axis_reload_tdata,
    output logic              m_axis_reload_tlast,
    input  logic              m_axis_reload_tready,
    output logic [1:0]        grant,
    output logic              pkt_done,
    output logic              len_err
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1, DRAIN} state_t;

    state_t state_q, state_d;
    logic   last_grant_q, last_grant_d;
    logic   pkt_done_q, pkt_done_d;
    logic   sel, pass, own, sv, sl, force_last, src_rdy;
`ifdef PFB_RELOAD_LEN_CHECK_EN
    logic             len_err_q, len_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // The beat counter must be able to reach NUM_COEFFS without wrapping
    if ((64'd1 << CNT_W) <= 64'(NUM_COEFFS)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for NUM_COEFFS");
    end

    // Steer the owning source onto the reload stream; everything visible is held low in reset
    always_comb begin
        sel  = (state_q == GNT1) || (state_q == DRAIN && last_grant_q);
        pass = (state_q == GNT0) || (state_q == GNT1);
        own  = pass || (state_q == DRAIN);
        sv   = sel ? s1_axis_tvalid : s0_axis_tvalid;
        sl   = sel ? s1_axis_tlast : s0_axis_tlast;
`ifdef PFB_RELOAD_LEN_CHECK_EN
        force_last = pass && (cnt_q == CNT_W'(NUM_COEFFS - 1));
        len_err    = len_err_q && !sync_reset;
`else
        force_last = 1'b0;
        len_err    = 1'b0;
`endif
        src_rdy              = !sync_reset && own && (state_q == DRAIN || m_axis_reload_tready);
        s0_axis_tready       = src_rdy && !sel;
        s1_axis_tready       = src_rdy && sel;
        m_axis_reload_tvalid = !sync_reset && pass && sv;
        m_axis_reload_tdata  = sel ? s1_axis_tdata : s0_axis_tdata;
        m_axis_reload_tlast  = sl || force_last;
        grant                = (sync_reset || !own) ? 2'b00 : (sel ? 2'b10 : 2'b01);
        pkt_done             = pkt_done_q && !sync_reset;
    end

    // Arbitrate in IDLE (skipping the completion cycle), track the set, police its length
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        pkt_done_d   = 1'b0;
`ifdef PFB_RELOAD_LEN_CHECK_EN
        len_err_d    = 1'b0;
        cnt_d        = cnt_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef PFB_RELOAD_LEN_CHECK_EN
                cnt_d = '0;
`endif
                if (!pkt_done_q && (s0_axis_tvalid || s1_axis_tvalid))
                    state_d = (s0_axis_tvalid && (!s1_axis_tvalid || last_grant_q)) ? GNT0 : GNT1;
            end
            GNT0, GNT1: begin
                if (sv && m_axis_reload_tready) begin
`ifdef PFB_RELOAD_LEN_CHECK_EN
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                    if (sl) begin
                        state_d      = IDLE;
                        last_grant_d = sel;
                        pkt_done_d   = 1'b1;
`ifdef PFB_RELOAD_LEN_CHECK_EN
                        len_err_d    = !force_last;
`endif
                    end else if (force_last) begin
                        state_d      = DRAIN;
                        last_grant_d = sel;
                    end
                end
            end
            DRAIN: begin
                if (sv && sl) begin
                    state_d    = IDLE;
                    pkt_done_d = 1'b1;
`ifdef PFB_RELOAD_LEN_CHECK_EN
                    len_err_d  = 1'b1;
`endif
                end
            end
        endcase
    end

    // State registers with synchronous reset; source 0 wins the first tie
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            pkt_done_q   <= 1'b0;
`ifdef PFB_RELOAD_LEN_CHECK_EN
            len_err_q    <= 1'b0;
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            pkt_done_q   <= pkt_done_d;
`ifdef PFB_RELOAD_LEN_CHECK_EN
            len_err_q    <= len_err_d;
            cnt_q        <= cnt_d;
`endif
        end
    end
endmodule
